seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle shift/rotate unit for the 8-bit processor datapath. Shifts one bit position per clock.
- Performs right shifts and rotates natively, so the datapath no longer needs the bit-reversal trick (reverse, shift left, reverse back) to get right shifts.
- The control unit starts an operation with a START pulse and stalls the PC while BUSY is high. It picks up RESULT in the cycle DONE is high.

Parameters:
- WIDTH, 8: operand width in bits. Must be a power of 2 and at least 2.
- SHAMT_W, 8: width of the shift-amount port.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request pulse; sampled on the rising edge.
- OPCODE  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR.
- DATA  input  WIDTH  operand; sampled with START.
- SHAMT  input  SHAMT_W  shift amount, unsigned; sampled with START.
- RESULT  output  WIDTH  registered result; held until the next completion.
- BUSY  output  1  high while shifting; new START is ignored while high.
- DONE  output  1  one-cycle pulse; RESULT is valid in this cycle.

Behaviour:
- Reset: when RESET goes low, the block enters IDLE immediately (asynchronously) with RESULT = 0, BUSY = 0, DONE = 0; internal shift register and counter are cleared.
  - Reset mid-operation aborts the operation; no DONE is produced for it.
- FSM states: IDLE, SHIFT, FIN.
  - BUSY = 1 only in SHIFT. DONE = 1 only in FIN. Both are registered (decoded from state flops).
- START acceptance: START is accepted in IDLE and in FIN, so back-to-back operations need no bubble. START is ignored in SHIFT.
- On an accepted START at edge t0, the block latches DATA into the shift register, latches OPCODE, and loads the counter with an effective count:
  - SLL, SRL, SRA: count = min(SHAMT, WIDTH).
  - ROR: count = SHAMT mod WIDTH, i.e. SHAMT[$clog2(WIDTH)-1:0].
- Counter width: $clog2(WIDTH)+1 bits, so it can hold the value WIDTH.
- Transitions out of the START edge:
  - count > 0: next state SHIFT.
  - count = 0: next state FIN, and RESULT <= DATA at the same edge.
- SHIFT state, per edge:
  - Perform one 1-bit operation on the shift register:
    - SLL: shift left, fill bit 0 with 0.
    - SRL: shift right, fill the MSB with 0.
    - SRA: shift right, fill the MSB with the old MSB.
    - ROR: rotate right; old bit 0 moves to the MSB.
  - Decrement the counter.
  - If the counter was 1 before the decrement: go to FIN and load RESULT with the shifted value.
- FIN state: DONE = 1 for exactly one cycle. Next state is IDLE, or the load step above if START is high.
- Latency: with effective count n, DONE is high in the cycle after edge t0+max(n,1). RESULT changes only at that edge.
- RESULT never shows intermediate shift values.
- SLL/SRL with SHAMT >= WIDTH gives 0. SRA with SHAMT >= WIDTH gives all bits equal to the sign bit.
- OPCODE, DATA and SHAMT are don't-care outside the START edge.

Test Plan:
1. SLL, DATA = 0x81, SHAMT = 1 -> BUSY high for 1 cycle, then DONE for 1 cycle with RESULT = 0x02; RESULT stays 0x02 afterwards.
2. SRA, DATA = 0x90, SHAMT = 3 -> BUSY high for 3 cycles, DONE with RESULT = 0xF2. Then SRL, DATA = 0x90, SHAMT = 3 -> RESULT = 0x12.
3. ROR, DATA = 0xA5, SHAMT = 12 -> effective count 4, BUSY high for 4 cycles, RESULT = 0x5A. Also SRL, DATA = 0xFF, SHAMT = 200 -> BUSY high for 8 cycles, RESULT = 0x00.
4. SLL, DATA = 0x3C, SHAMT = 0 -> BUSY never asserts; DONE in the cycle after START with RESULT = 0x3C.
5. Back-to-back and ignored START:
   - START (SLL 0x01 by 2) during FIN of a previous op is accepted; the next DONE carries 0x04.
   - A START pulse (SRL 0xFF by 1) during BUSY is ignored: RESULT = 0x04 and exactly one DONE follows.
6. Reset abort: START SLL 0x01 by 7, drive RESET low after 3 edges -> RESULT = 0, BUSY = 0, DONE = 0 immediately. After RESET goes high, no DONE appears until a new START.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit (SLL, SRL, SRA, ROR), one bit position per clock.
// Ports: CLK/RESET (async active-low); START+OPCODE+DATA+SHAMT request; RESULT/BUSY/DONE status.
// Latency: DONE is high max(n,1) cycles after the START edge; START is ignored while BUSY.
module seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [1:0]         OPCODE,
  input  logic [WIDTH-1:0]   DATA,
  input  logic [SHAMT_W-1:0] SHAMT,
  output logic [WIDTH-1:0]   RESULT,
  output logic               BUSY,
  output logic               DONE
);

  // Counter must be able to hold WIDTH itself, hence the extra bit.
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIN   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CW-1:0]    eff_cnt;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Effective count: rotates wrap modulo WIDTH, shifts saturate at WIDTH
  // (a full-width shift already yields the final all-fill value).
  always_comb begin
    if (OPCODE == 2'b11) begin
      eff_cnt = CW'(int'(SHAMT) % WIDTH);
    end else if (int'(SHAMT) >= WIDTH) begin
      eff_cnt = CW'(WIDTH);
    end else begin
      eff_cnt = CW'(SHAMT);
    end
  end

  // One-bit step of the latched operation.
  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {sreg_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, sreg_q[WIDTH-1:1]};
      OP_SRA:  shifted = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
      default: shifted = {sreg_q[0], sreg_q[WIDTH-1:1]};
    endcase
  end

  // FIN accepts a new request so back-to-back operations need no bubble.
  assign accept = START && (state_q != SHIFT);

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;

    if (accept) begin
      sreg_d = DATA;
      op_d   = OPCODE;
      cnt_d  = eff_cnt;
      if (eff_cnt == '0) begin
        state_d  = FIN;
        result_d = DATA;
      end else begin
        state_d = SHIFT;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          sreg_d = shifted;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d  = FIN;
            result_d = shifted;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status decoded purely from state flops: no combinational input-to-output path.
  assign RESULT = result_q;
  assign BUSY   = (state_q == SHIFT);
  assign DONE   = (state_q == FIN);

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized + directed stimulus against an arithmetic reference model.
// Driver pushes expected {result, busy length} per request; monitor pops on every DONE.
// Driver waits for BUSY low before each request; every wait is cycle-bounded.
module tb_seq_shifter;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   opcode;
  logic [W-1:0] data;
  logic [7:0]   shamt;
  logic [W-1:0] result;
  logic         busy;
  logic         done;

  seq_shifter #(.WIDTH(W), .SHAMT_W(8)) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .START  (start),
    .OPCODE (opcode),
    .DATA   (data),
    .SHAMT  (shamt),
    .RESULT (result),
    .BUSY   (busy),
    .DONE   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    int         busy_len;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on an 8-bit value.
  function automatic logic [7:0] ref_res(input int op, input int d, input int s);
    int r;
    int sd;
    int k;
    case (op)
      0: r = (s >= 8) ? 0 : (d << s);
      1: r = (s >= 8) ? 0 : (d >> s);
      2: begin
        sd = (d >= 128) ? d - 256 : d;
        r  = sd >>> ((s >= 8) ? 8 : s);
      end
      default: begin
        k = s % 8;
        r = (d >> k) | (d << (8 - k));
      end
    endcase
    return r[7:0];
  endfunction

  function automatic int ref_busy(input int op, input int s);
    if (op == 3) return s % 8;
    return (s >= 8) ? 8 : s;
  endfunction

  // Monitor: counts BUSY cycles, checks each DONE against the scoreboard,
  // and checks RESULT holds its last completed value between completions.
  logic [7:0] last_result = 8'h00;
  int         busy_cnt    = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_result = 8'h00;
        busy_cnt    = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          chk("busy_done_excl", {31'd0, busy}, 32'd0);
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", {24'd0, result}, {24'd0, e.res});
            chk("busy_len", busy_cnt, e.busy_len);
            last_result = e.res;
          end
          busy_cnt = 0;
        end else begin
          chk("result_hold", {24'd0, result}, {24'd0, last_result});
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (busy && k < 64) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 64) chk("ready_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Issue one request; returns #1 after the START edge. Inputs are scrambled
  // afterwards since they are don't-care outside the START edge.
  task automatic issue(input int op, input int d, input int s, input bit track);
    exp_t e;
    wait_ready();
    start  = 1'b1;
    opcode = op[1:0];
    data   = d[7:0];
    shamt  = s[7:0];
    if (track) begin
      e.res      = ref_res(op, d, s);
      e.busy_len = ref_busy(op, s);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    opcode = 2'($urandom);
    data   = 8'($urandom);
    shamt  = 8'($urandom);
  endtask

  initial begin
    int op, d, s, gap, k;
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 2'b00;
    data   = 8'h00;
    shamt  = 8'h00;
    #3;
    chk("reset_result", {24'd0, result}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    issue(0, 8'h81, 1, 1);
    issue(2, 8'h90, 3, 1);
    issue(1, 8'h90, 3, 1);
    issue(3, 8'hA5, 12, 1);
    issue(1, 8'hFF, 200, 1);
    issue(2, 8'h80, 255, 1);
    issue(0, 8'h3C, 0, 1);
    // Lands in FIN of the zero-count op; a START during BUSY must be ignored.
    issue(0, 8'h01, 2, 1);
    start  = 1'b1;
    opcode = 2'b01;
    data   = 8'hFF;
    shamt  = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready();
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic, mostly back-to-back with occasional idle gaps.
    for (int i = 0; i < 200; i++) begin
      op  = int'($urandom_range(0, 3));
      d   = int'($urandom_range(0, 255));
      s   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 10));
      gap = int'($urandom_range(0, 3));
      issue(op, d, s, 1);
      if (gap == 3) begin
        wait_ready();
        repeat (2) @(posedge clk);
        #1;
      end
    end

    // Reset abort: no DONE may be produced for the aborted request.
    wait_ready();
    repeat (2) @(posedge clk);
    #1;
    issue(0, 8'h01, 7, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    // Recovery after reset.
    issue(3, 8'h01, 1, 1);

    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("drain_sb", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
